// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//
// Sequential RV32I instruction encoder and program loader. It accepts
// field-level requests over a valid/ready handshake and packs each one into a
// 32-bit instruction word. It then writes the words to consecutive
// instruction-memory addresses starting at 0.
//
// Optional feature macro: ENCODER_RANGE_CHECK_EN
//   When defined, an immediate outside its field range drops the request
//   (err set, no write). When undefined, low-order bits are taken as-is.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             begin a load (honoured only in IDLE)
//   in_valid_i/ready_o  request handshake
//   in_kind_i           0=lw 1=sw 2=R 3=beq 4=I 5=jal (6,7 unsupported)
//   in_funct3_i         funct3 for R and I kinds
//   in_funct7b5_i       funct7 bit 5 for R and I shifts
//   in_rd/rs1/rs2_i     register fields
//   in_imm_i            signed immediate (byte offset for beq/jal)
//   in_last_i           final word of the program
//   imem_wren_o         instruction-memory write strobe
//   imem_addr_o         word address
//   imem_wdata_o        encoded instruction
//   busy_o, done_o      not-idle flag, one-cycle completion pulse
//   full_o, err_o       sticky: load ended at DEPTH-1 / a request was dropped
//   count_o             words written in the current load
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | in_ready high, waiting for a request
// WRITE | writing the encoded word at addr
// DONE  | one-cycle completion pulse
module instr_encoder_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        in_kind_i,
    input  logic [2:0]        in_funct3_i,
    input  logic              in_funct7b5_i,
    input  logic [4:0]        in_rd_i,
    input  logic [4:0]        in_rs1_i,
    input  logic [4:0]        in_rs2_i,
    input  logic [20:0]       in_imm_i,
    input  logic              in_last_i,
    output logic              imem_wren_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              full_o,
    output logic              err_o,
    output logic [ADDR_W:0]   count_o
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              last_q, last_d;
    logic              full_q, full_d;
    logic              err_q, err_d;

    logic [31:0] enc;
    logic        kind_ok;
    logic        range_ok;
    logic        is_shift;

    // I-type slli/srli/srai carry funct7 in the upper immediate bits.
    assign is_shift = (in_kind_i == 3'd4) &&
                      ((in_funct3_i == 3'b001) || (in_funct3_i == 3'b101));

    always_comb begin
        enc     = '0;
        kind_ok = 1'b1;
        case (in_kind_i)
            3'd0: enc = {in_imm_i[11:0], in_rs1_i, 3'b010, in_rd_i, 7'b0000011};
            3'd1: enc = {in_imm_i[11:5], in_rs2_i, in_rs1_i, 3'b010,
                         in_imm_i[4:0], 7'b0100011};
            3'd2: enc = {1'b0, in_funct7b5_i, 5'b00000, in_rs2_i, in_rs1_i,
                         in_funct3_i, in_rd_i, 7'b0110011};
            3'd3: enc = {in_imm_i[12], in_imm_i[10:5], in_rs2_i, in_rs1_i, 3'b000,
                         in_imm_i[4:1], in_imm_i[11], 7'b1100011};
            3'd4: begin
                if (is_shift) begin
                    enc = {1'b0, in_funct7b5_i, 5'b00000, in_imm_i[4:0], in_rs1_i,
                           in_funct3_i, in_rd_i, 7'b0010011};
                end else begin
                    enc = {in_imm_i[11:0], in_rs1_i, in_funct3_i, in_rd_i, 7'b0010011};
                end
            end
            3'd5: enc = {in_imm_i[20], in_imm_i[10:1], in_imm_i[11], in_imm_i[19:12],
                         in_rd_i, 7'b1101111};
            default: kind_ok = 1'b0;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    logic signed [20:0] imm_s;
    assign imm_s = $signed(in_imm_i);

    always_comb begin
        range_ok = 1'b1;
        case (in_kind_i)
            3'd0, 3'd1: range_ok = (imm_s >= -21'sd2048) && (imm_s <= 21'sd2047);
            3'd3: range_ok = (imm_s >= -21'sd4096) && (imm_s <= 21'sd4094) && !in_imm_i[0];
            3'd4: begin
                if (is_shift) begin
                    range_ok = (in_imm_i[20:5] == '0);
                end else begin
                    range_ok = (imm_s >= -21'sd2048) && (imm_s <= 21'sd2047);
                end
            end
            // The 21-bit field already spans the jal range; only parity matters.
            3'd5: range_ok = !in_imm_i[0];
            default: range_ok = 1'b1;
        endcase
    end
`else
    assign range_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        full_d  = full_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (in_valid_i) begin
                    if (kind_ok && range_ok) begin
                        wdata_d = enc;
                        last_d  = in_last_i;
                        state_d = WRITE;
                    end else begin
                        // Dropped request: handshake completes, nothing is written.
                        err_d = 1'b1;
                        if (in_last_i) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            WRITE: begin
                count_d = count_q + (ADDR_W + 1)'(1);
                if (addr_q == ADDR_MAX) begin
                    full_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = last_q ? DONE : LOAD;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    // Reset gates the strobe so a write pending in WRITE never reaches memory.
    assign imem_wren_o  = (state_q == WRITE) && !rst_i;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign in_ready_o   = (state_q == LOAD);
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign full_o       = full_q;
    assign err_o        = err_q;
    assign count_o      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    typedef struct {
        int kind; int f3; int f7b5; int rd; int rs1; int rs2; int imm; bit last;
    } req_t;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_ready, in_funct7b5, in_last;
    logic [2:0]    in_kind, in_funct3;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [20:0]   in_imm;
    logic          imem_wren, busy, done, full, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    wr_t  wlog[$];
    wr_t  exp_q[$];
    req_t reqs[$];
    int   m_addr, m_count;
    bit   m_full, m_err, m_end;

    always #5 clk = ~clk;

    instr_encoder_loader #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_kind_i(in_kind), .in_funct3_i(in_funct3), .in_funct7b5_i(in_funct7b5),
        .in_rd_i(in_rd), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
        .in_imm_i(in_imm), .in_last_i(in_last),
        .imem_wren_o(imem_wren), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
        .busy_o(busy), .done_o(done), .full_o(full), .err_o(err), .count_o(count)
    );

    always @(negedge clk) begin
        if (imem_wren === 1'b1) wlog.push_back('{int'(imem_addr), imem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic req_t mk(int kind, int f3, int f7b5, int rd, int rs1, int rs2,
                                int imm, bit last);
        req_t r;
        r.kind = kind; r.f3 = f3; r.f7b5 = f7b5; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
        r.imm = imm; r.last = last;
        return r;
    endfunction

    // Reference encoder: builds each word by shifting and masking fields.
    function automatic logic [31:0] model_word(req_t r);
        int unsigned u, w, rd, rs1, rs2, f3, f7;
        u = r.imm; rd = r.rd; rs1 = r.rs1; rs2 = r.rs2; f3 = r.f3; f7 = r.f7b5;
        w = 0;
        case (r.kind)
            0: w = ((u & 'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03;
            1: w = (((u >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                   | ((u & 'h1F) << 7) | 'h23;
            2: w = (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
            3: w = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (rs2 << 20)
                   | (rs1 << 15) | (((u >> 1) & 'hF) << 8) | (((u >> 11) & 1) << 7) | 'h63;
            4: begin
                if (f3 == 1 || f3 == 5)
                    w = (f7 << 30) | ((u & 'h1F) << 20) | (rs1 << 15) | (f3 << 12)
                        | (rd << 7) | 'h13;
                else
                    w = ((u & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
            end
            5: w = (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21)
                   | (((u >> 11) & 1) << 20) | (((u >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
            default: w = 0;
        endcase
        return w;
    endfunction

    function automatic bit model_ok(req_t r);
        if (r.kind >= 6) return 0;
`ifdef ENCODER_RANGE_CHECK_EN
        case (r.kind)
            0, 1: return (r.imm >= -2048 && r.imm <= 2047);
            3: return (r.imm >= -4096 && r.imm <= 4094 && (r.imm % 2 == 0));
            4: begin
                if (r.f3 == 1 || r.f3 == 5) return (r.imm >= 0 && r.imm <= 31);
                return (r.imm >= -2048 && r.imm <= 2047);
            end
            5: return (r.imm % 2 == 0);
            default: return 1;
        endcase
`else
        return 1;
`endif
    endfunction

    function automatic void model_step(req_t r);
        if (!model_ok(r)) begin
            m_err = 1;
            if (r.last) m_end = 1;
        end else begin
            exp_q.push_back('{m_addr, model_word(r)});
            m_count++;
            if (m_addr == DEPTH - 1) begin
                m_full = 1;
                m_end  = 1;
            end else begin
                if (r.last) m_end = 1;
                m_addr++;
            end
        end
    endfunction

    task automatic send(input req_t r);
        int n;
        in_kind = 3'(r.kind); in_funct3 = 3'(r.f3); in_funct7b5 = r.f7b5[0];
        in_rd = 5'(r.rd); in_rs1 = 5'(r.rs1); in_rs2 = 5'(r.rs2);
        in_imm = 21'(r.imm); in_last = r.last;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) check("ready_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_load(input string tag);
        int n;
        m_addr = 0; m_count = 0; m_full = 0; m_err = 0; m_end = 0;
        exp_q.delete();
        wlog.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < reqs.size(); i++) begin
            if (m_end) break;
            model_step(reqs[i]);
            send(reqs[i]);
        end
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_count"}, 32'(count), 32'(m_count));
        check({tag, "_full"}, 32'(full), 32'(m_full));
        check({tag, "_err"}, 32'(err), 32'(m_err));
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_nwrites"}, 32'(wlog.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
            check({tag, "_addr"}, 32'(wlog[i].addr), 32'(exp_q[i].addr));
            check({tag, "_data"}, wlog[i].data, exp_q[i].data);
        end
    endtask

    initial begin
        logic [31:0] seq_exp [5];
        req_t r;
        int   n;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_kind = '0; in_funct3 = '0;
        in_funct7b5 = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        in_last = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_wren", 32'(imem_wren), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        rst = 1'b0;
        tick();

        // addi x1,x0,5: write in the cycle after the handshake, done one cycle later
        wlog.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("addi_ready", 32'(in_ready), 32'd1);
        send(mk(4, 0, 0, 1, 0, 0, 5, 1'b1));
        check("addi_wren", 32'(imem_wren), 32'd1);
        check("addi_addr", 32'(imem_addr), 32'd0);
        check("addi_data", imem_wdata, 32'h00500093);
        tick();
        check("addi_done", 32'(done), 32'd1);
        check("addi_count", 32'(count), 32'd1);
        tick();
        check("addi_idle", 32'(busy), 32'd0);

        // Five-instruction program with known words
        reqs.delete();
        reqs.push_back(mk(0, 0, 0, 2, 1, 0, 8, 1'b0));
        reqs.push_back(mk(1, 0, 0, 0, 1, 2, 4, 1'b0));
        reqs.push_back(mk(2, 0, 0, 3, 1, 2, 0, 1'b0));
        reqs.push_back(mk(3, 0, 0, 0, 1, 2, -4, 1'b0));
        reqs.push_back(mk(5, 0, 0, 1, 0, 0, 8, 1'b1));
        run_load("seq");
        seq_exp[0] = 32'h0080A103; seq_exp[1] = 32'h0020A223; seq_exp[2] = 32'h002081B3;
        seq_exp[3] = 32'hFE208EE3; seq_exp[4] = 32'h008000EF;
        for (int i = 0; i < 5 && i < wlog.size(); i++) check("seq_known", wlog[i].data, seq_exp[i]);

        // Unsupported kind between two valid requests: no gap in addresses
        reqs.delete();
        reqs.push_back(mk(4, 0, 0, 1, 0, 0, 5, 1'b0));
        reqs.push_back(mk(7, 0, 0, 1, 2, 3, 1, 1'b0));
        reqs.push_back(mk(2, 0, 1, 3, 1, 2, 0, 1'b1));
        run_load("drop");
        check("drop_err", 32'(err), 32'd1);
        if (wlog.size() > 1) check("drop_gap", 32'(wlog[1].addr), 32'd1);

        // Dropped request carrying last ends the load without a write
        reqs.delete();
        reqs.push_back(mk(6, 0, 0, 1, 0, 0, 0, 1'b1));
        run_load("droplast");

        // Fill the memory with no last marker
        reqs.delete();
        for (int i = 0; i < DEPTH + 2; i++) reqs.push_back(mk(2, i % 8, 0, i, i + 1, i + 2, 0, 1'b0));
        run_load("full");
        check("full_flag", 32'(full), 32'd1);
        check("full_count", 32'(count), 32'(DEPTH));
        if (wlog.size() == DEPTH) check("full_lastaddr", 32'(wlog[DEPTH-1].addr), 32'(DEPTH - 1));

        // Reset during the WRITE cycle of the second word
        wlog.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        send(mk(4, 0, 0, 1, 0, 0, 1, 1'b0));
        send(mk(4, 0, 0, 2, 0, 0, 2, 1'b0));
        rst = 1'b1;
        start = 1'b1;
        #1;
        check("rstw_wren", 32'(imem_wren), 32'd0);
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("rstw_busy", 32'(busy), 32'd0);
        check("rstw_ready", 32'(in_ready), 32'd0);
        check("rstw_addr", 32'(imem_addr), 32'd0);
        check("rstw_wdata", imem_wdata, 32'd0);
        check("rstw_count", 32'(count), 32'd0);
        check("rstw_flags", {29'd0, done, full, err}, 32'd0);
        check("rstw_nwrites", 32'(wlog.size()), 32'd1);
        tick();

        // Out-of-range addi immediate
        reqs.delete();
        reqs.push_back(mk(4, 0, 0, 1, 0, 0, 2048, 1'b1));
        run_load("imm2048");
`ifdef ENCODER_RANGE_CHECK_EN
        check("imm2048_nowrite", 32'(wlog.size()), 32'd0);
`else
        if (wlog.size() > 0) check("imm2048_word", wlog[0].data, 32'h80000093);
`endif

        // Randomised loads
        for (int l = 0; l < 8; l++) begin
            reqs.delete();
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                r.kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7))
                                                     : int'($urandom_range(0, 5));
                r.f3   = int'($urandom_range(0, 7));
                r.f7b5 = int'($urandom_range(0, 1));
                r.rd   = int'($urandom_range(0, 31));
                r.rs1  = int'($urandom_range(0, 31));
                r.rs2  = int'($urandom_range(0, 31));
                if ($urandom_range(0, 1) == 1) r.imm = int'($urandom_range(0, 8191)) - 4096;
                else r.imm = int'($urandom_range(0, 2097151)) - 1048576;
                r.last = (i == n - 1);
                reqs.push_back(r);
            end
            run_load("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
